// File: rtl/calc_exec_ctrl.sv
// Keypad calculator execution sequencer: BCD load, add/sub/mul/div on one
// shared datapath, then double-dabble back to 4 BCD digits for the display.
module calc_exec_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a_tens,
    input  logic [3:0] a_ones,
    input  logic [3:0] b_tens,
    input  logic [3:0] b_ones,
    input  logic [3:0] op,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       neg,
    output logic [3:0] res_d3,
    output logic [3:0] res_d2,
    output logic [3:0] res_d1,
    output logic [3:0] res_d0
);

    typedef enum logic [2:0] {IDLE, LOAD, EXEC, CONV, DONE} state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] at;
        logic [3:0] ao;
        logic [3:0] bt;
        logic [3:0] bo;
    } req_t;

    localparam logic [3:0] OP_ADD = 4'ha;
    localparam logic [3:0] OP_SUB = 4'hb;
    localparam logic [3:0] OP_MUL = 4'hc;
    localparam logic [3:0] OP_DIV = 4'hd;

    state_t      state, state_nxt;
    req_t        req;
    logic [6:0]  a_bin, b_bin;
    logic [6:0]  a_load, b_load;
    logic        load_err;
    logic [13:0] acc, acc_nxt;
    logic [6:0]  rem, rem_nxt;
    logic [6:0]  dq, dq_nxt;
    logic [7:0]  trial;
    logic        neg_r, neg_nxt;
    logic [3:0]  cnt;
    logic        exec_last, conv_last;
    logic [29:0] dd, dd_nxt;

    function automatic logic [15:0] dd_adj(input logic [15:0] b);
        logic [15:0] r;
        for (int i = 0; i < 4; i++)
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        return r;
    endfunction

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // x10 as x8 + x2; overflow on bad digits is harmless, the error path discards it
    always_comb begin
        a_load   = {req.at, 3'b000} + {2'b00, req.at, 1'b0} + {3'b000, req.ao};
        b_load   = {req.bt, 3'b000} + {2'b00, req.bt, 1'b0} + {3'b000, req.bo};
        load_err = (req.at > 4'd9) || (req.ao > 4'd9) || (req.bt > 4'd9) || (req.bo > 4'd9)
                || (req.op < OP_ADD) || (req.op > OP_DIV)
                || ((req.op == OP_DIV) && (b_load == 7'd0));
    end

    always_comb begin
        acc_nxt = acc;
        rem_nxt = rem;
        dq_nxt  = dq;
        neg_nxt = neg_r;
        trial   = 8'd0;
        case (req.op)
            OP_ADD: acc_nxt = {7'd0, a_bin} + {7'd0, b_bin};
            OP_SUB: begin
                if (a_bin >= b_bin) begin
                    acc_nxt = {7'd0, a_bin - b_bin};
                    neg_nxt = 1'b0;
                end else begin
                    acc_nxt = {7'd0, b_bin - a_bin};
                    neg_nxt = 1'b1;
                end
            end
            OP_MUL: begin
                if (b_bin[cnt[2:0]])
                    acc_nxt = acc + ({7'd0, a_bin} << cnt[2:0]);
            end
            default: begin
                // restoring division, dividend bits shift out of dq MSB-first
                trial = {rem, dq[6]};
                if (trial >= {1'b0, b_bin}) begin
                    rem_nxt = trial[6:0] - b_bin;
                    dq_nxt  = {dq[5:0], 1'b1};
                end else begin
                    rem_nxt = trial[6:0];
                    dq_nxt  = {dq[5:0], 1'b0};
                end
                acc_nxt = {7'd0, dq_nxt};
            end
        endcase
        exec_last = (req.op == OP_ADD) || (req.op == OP_SUB) || (cnt == 4'd6);
        conv_last = (cnt == 4'd13);
        dd_nxt    = {dd_adj(dd[29:14]), dd[13:0]} << 1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = load_err ? DONE : EXEC;
            EXEC:    if (exec_last) state_nxt = CONV;
            CONV:    if (conv_last) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req    <= '0;
            a_bin  <= '0;
            b_bin  <= '0;
            acc    <= '0;
            rem    <= '0;
            dq     <= '0;
            neg_r  <= 1'b0;
            cnt    <= '0;
            dd     <= '0;
            err    <= 1'b0;
            neg    <= 1'b0;
            res_d3 <= '0;
            res_d2 <= '0;
            res_d1 <= '0;
            res_d0 <= '0;
        end else begin
            case (state)
                IDLE: if (start) req <= '{op: op, at: a_tens, ao: a_ones, bt: b_tens, bo: b_ones};
                LOAD: begin
                    a_bin <= a_load;
                    b_bin <= b_load;
                    acc   <= '0;
                    rem   <= '0;
                    dq    <= a_load;
                    neg_r <= 1'b0;
                    cnt   <= '0;
                    if (load_err) begin
                        err    <= 1'b1;
                        neg    <= 1'b0;
                        res_d3 <= '0;
                        res_d2 <= '0;
                        res_d1 <= '0;
                        res_d0 <= '0;
                    end
                end
                EXEC: begin
                    acc   <= acc_nxt;
                    rem   <= rem_nxt;
                    dq    <= dq_nxt;
                    neg_r <= neg_nxt;
                    if (exec_last) begin
                        cnt <= '0;
                        dd  <= {16'd0, acc_nxt};
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                CONV: begin
                    dd <= dd_nxt;
                    if (conv_last) begin
                        cnt    <= '0;
                        err    <= 1'b0;
                        neg    <= neg_r;
                        res_d3 <= dd_nxt[29:26];
                        res_d2 <= dd_nxt[25:22];
                        res_d1 <= dd_nxt[21:18];
                        res_d0 <= dd_nxt[17:14];
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_exec_ctrl.sv
// Directed bench for calc_exec_ctrl: reference model feeds a scoreboard queue,
// popped and compared at every done pulse, plus latency and busy checks.
module tb_calc_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a_tens = '0, a_ones = '0, b_tens = '0, b_ones = '0, op = '0;
    logic       busy, done, err, neg;
    logic [3:0] res_d3, res_d2, res_d1, res_d0;

    calc_exec_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_tens(a_tens), .a_ones(a_ones), .b_tens(b_tens), .b_ones(b_ones), .op(op),
        .busy(busy), .done(done), .err(err), .neg(neg),
        .res_d3(res_d3), .res_d2(res_d2), .res_d1(res_d1), .res_d0(res_d0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d3, d2, d1, d0;
        logic       neg, err;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [3:0] at, ao, bt, bo, o);
        exp_t e;
        int a, b, r;
        e = '{d3: 0, d2: 0, d1: 0, d0: 0, neg: 0, err: 0, lat: 0};
        a = at * 10 + ao;
        b = bt * 10 + bo;
        r = 0;
        if (at > 9 || ao > 9 || bt > 9 || bo > 9 || o < 4'ha || o > 4'hd || (o == 4'hd && b == 0)) begin
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
        case (o)
            4'ha: begin r = a + b; e.lat = 16; end
            4'hb: begin
                if (a >= b) r = a - b;
                else begin r = b - a; e.neg = 1'b1; end
                e.lat = 16;
            end
            4'hc: begin r = a * b; e.lat = 22; end
            default: begin r = a / b; e.lat = 22; end
        endcase
        e.d3 = 4'((r / 1000) % 10);
        e.d2 = 4'((r / 100) % 10);
        e.d1 = 4'((r / 10) % 10);
        e.d0 = 4'(r % 10);
        return e;
    endfunction

    task automatic check_result(input string tag, input exp_t x, input int n);
        check({tag, " latency"}, n, x.lat);
        check({tag, " digits"}, {res_d3, res_d2, res_d1, res_d0}, {x.d3, x.d2, x.d1, x.d0});
        check({tag, " neg"}, neg, x.neg);
        check({tag, " err"}, err, x.err);
    endtask

    // one accepted request: drive, push model result, wait bounded for done, pop and compare
    task automatic run(input string tag, input logic [3:0] at, ao, bt, bo, o);
        int n;
        bit seen;
        @(negedge clk);
        a_tens = at; a_ones = ao; b_tens = bt; b_ones = bo; op = o; start = 1'b1;
        sb.push_back(model(at, ao, bt, bo, o));
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " busy@k"}, busy, 1'b1);
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done) seen = 1;
        end
        check({tag, " done seen"}, seen, 1'b1);
        if (seen && sb.size() > 0) check_result(tag, sb.pop_front(), n);
        @(posedge clk); #1;
        check({tag, " done single"}, done, 1'b0);
        check({tag, " busy low"}, busy, 1'b0);
    endtask

    initial begin
        exp_t e;
        int dn, first;

        #12;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset flags", {err, neg}, 2'b00);
        check("reset digits", {res_d3, res_d2, res_d1, res_d0}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        run("add 12+34", 4'd1, 4'd2, 4'd3, 4'd4, 4'ha);
        run("sub 05-37", 4'd0, 4'd5, 4'd3, 4'd7, 4'hb);
        run("sub 37-37", 4'd3, 4'd7, 4'd3, 4'd7, 4'hb);
        run("mul 99x99", 4'd9, 4'd9, 4'd9, 4'd9, 4'hc);
        run("div 87/4", 4'd8, 4'd7, 4'd0, 4'd4, 4'hd);
        run("div 3/7", 4'd0, 4'd3, 4'd0, 4'd7, 4'hd);
        run("err div0", 4'd4, 4'd2, 4'd0, 4'd0, 4'hd);
        run("err op e", 4'd1, 4'd1, 4'd2, 4'd2, 4'he);
        run("err digit", 4'd1, 4'hb, 4'd2, 4'd2, 4'ha);
        run("clear err", 4'd5, 4'd0, 4'd2, 4'd5, 4'ha);

        for (int i = 0; i < 8; i++) begin
            logic [3:0] ro;
            ro = 4'(4'ha + $urandom_range(0, 3));
            run("rand", 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)), 4'($urandom_range(1, 9)), ro);
        end

        // starts during busy (mid-EXEC and at the CONV->DONE edge) must be dropped
        @(negedge clk);
        a_tens = 4'd2; a_ones = 4'd5; b_tens = 4'd0; b_ones = 4'd4; op = 4'hc; start = 1'b1;
        sb.push_back(model(4'd2, 4'd5, 4'd0, 4'd4, 4'hc));
        @(posedge clk); #1;
        start = 1'b0;
        dn = 0;
        first = 0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (n == 5 || n == 22) begin
                a_tens = 4'd1; a_ones = 4'd1; b_tens = 4'd1; b_ones = 4'd1; op = 4'ha; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                dn++;
                if (first == 0) first = n;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_result("busy start", e, n);
                end
            end
        end
        start = 1'b0;
        check("busy start done count", dn, 1);
        check("busy start first done", first, 22);
        check("busy start idle", busy, 1'b0);
        check("busy start result held", {res_d3, res_d2, res_d1, res_d0}, 16'h0100);

        // async reset in the middle of conversion
        run("mul before reset", 4'd9, 4'd9, 4'd9, 4'd9, 4'hc);
        @(negedge clk);
        a_tens = 4'd9; a_ones = 4'd9; b_tens = 4'd9; b_ones = 4'd9; op = 4'hc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset busy", busy, 1'b0);
        check("midreset done", done, 1'b0);
        check("midreset flags", {err, neg}, 2'b00);
        check("midreset digits", {res_d3, res_d2, res_d1, res_d0}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        run("after reset", 4'd1, 4'd2, 4'd3, 4'd4, 4'hc);
        check("scoreboard empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
